// File: rtl/pc_sequencer_16bit.sv
// -----------------------------------------------------------------------------
// pc_sequencer_16bit
//
// Registered 16-bit program-counter sequencer. It owns the PC register and
// drives the current PC into an internal 16-bit incrementer (pc_inc16). Each
// cycle the PC either holds, takes the incremented value, or takes an explicit
// load target. Increment wrap-around is captured in a sticky flag. A small
// run/halt FSM decides which inputs are honoured.
//
// Optional feature (macro PC_WRAP_TRAP_EN):
//   Defined   - a step at pc==16'hFFFF traps into FAULT. The PC holds at
//               16'hFFFF and only reset leaves FAULT.
//   Undefined - the PC wraps to 16'h0000, the FSM stays in RUN, and fault is 0.
//
// Parameters:
//   RESET_PC    PC value loaded on reset and on start from IDLE.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   leave IDLE and begin sequencing from RESET_PC
//   step        in   advance the PC by one in RUN
//   load        in   load load_addr into the PC in RUN or HALT
//   load_addr   in   [15:0] jump target
//   halt_req    in   request entry to HALT
//   resume      in   return from HALT to RUN
//   clr_ovf     in   clear the sticky overflow flag
//   pc          out  [15:0] current PC (registered)
//   running     out  high while in RUN
//   ovf_sticky  out  set when an increment wrapped from 16'hFFFF
//   fault       out  high in FAULT (constant 0 without PC_WRAP_TRAP_EN)
//   step_count  out  [15:0] accepted increments since reset or start (wraps)
// -----------------------------------------------------------------------------

// 16-bit incrementer: inc_a = a + 1, overflow flags the wrap from 16'hFFFF.
module pc_inc16 (
  input  logic [15:0] a,
  output logic [15:0] inc_a,
  output logic        overflow
);

  logic [16:0] sum;

  always_comb begin
    sum      = {1'b0, a} + 17'd1;
    inc_a    = sum[15:0];
    overflow = sum[16];
  end

endmodule

module pc_sequencer_16bit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        clr_ovf,
  output logic [15:0] pc,
  output logic        running,
  output logic        ovf_sticky,
  output logic        fault,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        ovf_set;

  logic [15:0] inc_a;
  logic        inc_ovf;

  pc_inc16 u_inc (
    .a        (pc_q),
    .inc_a    (inc_a),
    .overflow (inc_ovf)
  );

  // Next-state / datapath selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          cnt_d   = 16'd0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Priority: halt_req > load > step.
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (load) begin
          pc_d = load_addr;
        end else if (step) begin
          cnt_d   = cnt_q + 16'd1;
          ovf_set = inc_ovf;
`ifdef PC_WRAP_TRAP_EN
          // A wrapping step is counted and flagged but the PC keeps 16'hFFFF.
          if (inc_ovf) begin
            state_d = ST_FAULT;
          end else begin
            pc_d = inc_a;
          end
`else
          pc_d = inc_a;
`endif
        end
      end

      ST_HALT: begin
        // load and resume together: load applies and the FSM returns to RUN.
        if (load) begin
          pc_d = load_addr;
        end
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      ST_FAULT: begin
        // Terminal until reset.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Set has priority over clear.
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from registers or the state decode.
  assign pc         = pc_q;
  assign step_count = cnt_q;
  assign ovf_sticky = ovf_q;
  assign running    = (state_q == ST_RUN);
`ifdef PC_WRAP_TRAP_EN
  assign fault      = (state_q == ST_FAULT);
`else
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer_16bit.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer_16bit
//
// Directed bench for pc_sequencer_16bit with hand-computed expectations.
// Expectations that depend on PC_WRAP_TRAP_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_pc_sequencer_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, step, load, halt_req, resume, clr_ovf;
  logic [15:0] load_addr;
  logic [15:0] pc;
  logic        running, ovf_sticky, fault;
  logic [15:0] step_count;

  int n_assert = 0;
  int n_fail   = 0;

  pc_sequencer_16bit #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step       (step),
    .load       (load),
    .load_addr  (load_addr),
    .halt_req   (halt_req),
    .resume     (resume),
    .clr_ovf    (clr_ovf),
    .pc         (pc),
    .running    (running),
    .ovf_sticky (ovf_sticky),
    .fault      (fault),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; step = 0; load = 0; halt_req = 0; resume = 0; clr_ovf = 0;
    load_addr = 16'h0000;
  endtask

`ifdef PC_WRAP_TRAP_EN
  localparam logic [15:0] WRAP_PC  = 16'hFFFF;
  localparam logic [15:0] WRAP_RUN = 16'd0;
  localparam logic [15:0] WRAP_FLT = 16'd1;
`else
  localparam logic [15:0] WRAP_PC  = 16'h0000;
  localparam logic [15:0] WRAP_RUN = 16'd1;
  localparam logic [15:0] WRAP_FLT = 16'd0;
`endif

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_pc",      pc,                  16'h0000);
    check("rst_running", {15'd0, running},    16'd0);
    check("rst_ovf",     {15'd0, ovf_sticky}, 16'd0);
    check("rst_fault",   {15'd0, fault},      16'd0);
    check("rst_count",   step_count,          16'd0);
    tick();
    rst_n = 1'b1;

    // IDLE ignores step and load.
    step = 1; load = 1; load_addr = 16'h5555;
    tick();
    check("idle_pc",      pc,               16'h0000);
    check("idle_running", {15'd0, running}, 16'd0);
    idle_inputs();

    // start, then five steps.
    start = 1;
    tick();
    check("start_pc",      pc,               16'h0000);
    check("start_running", {15'd0, running}, 16'd1);
    start = 0; step = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("step_pc%0d", i), pc, 16'(i));
    end
    check("step_count5", step_count,         16'd5);
    check("run_running", {15'd0, running},   16'd1);

    // load beats step in RUN.
    load = 1; load_addr = 16'h1234;
    tick();
    check("load_pc",    pc,         16'h1234);
    check("load_count", step_count, 16'd5);
    load = 0;
    tick();
    check("after_load_pc",    pc,         16'h1235);
    check("after_load_count", step_count, 16'd6);

    // halt, then steps are ignored.
    step = 0; halt_req = 1;
    tick();
    check("halt_running", {15'd0, running}, 16'd0);
    check("halt_pc",      pc,               16'h1235);
    halt_req = 0; step = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_step_pc", pc, 16'h1235);
    end
    check("halt_count", step_count, 16'd6);

    // load + resume together from HALT.
    step = 0; load = 1; load_addr = 16'h00A0; resume = 1;
    tick();
    check("resume_pc",      pc,               16'h00A0);
    check("resume_running", {15'd0, running}, 16'd1);
    idle_inputs();

    // Wrap from 16'hFFFF.
    load = 1; load_addr = 16'hFFFF;
    tick();
    check("load_ffff", pc, 16'hFFFF);
    load = 0; step = 1;
    tick();
    check("wrap_pc",      pc,                  WRAP_PC);
    check("wrap_ovf",     {15'd0, ovf_sticky}, 16'd1);
    check("wrap_running", {15'd0, running},    WRAP_RUN);
    check("wrap_fault",   {15'd0, fault},      WRAP_FLT);
    check("wrap_count",   step_count,          16'd7);

`ifdef PC_WRAP_TRAP_EN
    // FAULT ignores everything except reset.
    step = 1; load = 1; load_addr = 16'h0123; resume = 1;
    tick();
    check("fault_hold_pc",    pc,             16'hFFFF);
    check("fault_hold_fault", {15'd0, fault}, 16'd1);
    check("fault_hold_count", step_count,     16'd7);
    idle_inputs();
`endif

    // Asynchronous reset between edges, with a step pending.
    idle_inputs();
    step = 1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pc",      pc,                  16'h0000);
    check("arst_ovf",     {15'd0, ovf_sticky}, 16'd0);
    check("arst_fault",   {15'd0, fault},      16'd0);
    check("arst_running", {15'd0, running},    16'd0);
    check("arst_count",   step_count,          16'd0);
    tick();
    check("arst_held_pc", pc, 16'h0000);
    idle_inputs();
    rst_n = 1'b1;

    // clr_ovf clears the flag on its own.
    start = 1;
    tick();
    start = 0; load = 1; load_addr = 16'hFFFF;
    tick();
    load = 0; step = 1;
    tick();
    check("set_ovf", {15'd0, ovf_sticky}, 16'd1);
    step = 0; clr_ovf = 1;
    tick();
    check("clr_ovf", {15'd0, ovf_sticky}, 16'd0);
    clr_ovf = 0;

    // Set beats clear when coincident with a wrapping step.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1;
    tick();
    start = 0; load = 1; load_addr = 16'hFFFF;
    tick();
    load = 0; step = 1; clr_ovf = 1;
    tick();
    check("set_wins_ovf", {15'd0, ovf_sticky}, 16'd1);
    check("set_wins_pc",  pc,                  WRAP_PC);
    idle_inputs();
    tick();
    check("clr_after_set", {15'd0, ovf_sticky}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
